// File: rtl/branch_predict_unit.sv
// Branch resolution and direction prediction: a PC-indexed table of 2-bit
// saturating counters, registered redirect on mispredict/jump, and perf counters.
module branch_predict_unit #(
    parameter int          IDX_BITS = 6,
    parameter int          XLEN     = 32,
    parameter int          CNT_W    = 32,
    parameter logic [1:0]  INIT_CTR = 2'b01
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [XLEN-1:0] if_pc,
    output logic            if_pred_taken,
    input  logic            ex_valid,
    input  logic [6:0]      ex_op,
    input  logic [2:0]      ex_funct3,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_zero,
    input  logic            ex_overflow,
    input  logic            ex_carry,
    input  logic            ex_negative,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mispred_count
);

    localparam int         ENTRIES   = 1 << IDX_BITS;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        CLS_NONE,
        CLS_BRANCH,
        CLS_JAL,
        CLS_JALR
    } ctrl_class_e;

    logic [1:0]          r_bht [ENTRIES];
    logic                r_redirect;
    logic [XLEN-1:0]     r_redirect_pc;
    logic [CNT_W-1:0]    r_br_count;
    logic [CNT_W-1:0]    r_mispred_count;

    ctrl_class_e         w_cls;
    logic                w_cond_ok;
    logic                w_actual;
    logic                w_br_resolve;
    logic                w_mispred;
    logic [IDX_BITS-1:0] w_if_idx;
    logic [IDX_BITS-1:0] w_ex_idx;
    logic [1:0]          w_ctr_cur;
    logic [1:0]          w_ctr_next;
    logic [XLEN-1:0]     w_fallthru;
    logic                w_unused;

    assign w_if_idx   = if_pc[IDX_BITS+1:2];
    assign w_ex_idx   = ex_pc[IDX_BITS+1:2];
    assign w_fallthru = ex_pc + XLEN'(4);

    // Reads the pre-update entry: a same-cycle update to this index is not bypassed.
    assign if_pred_taken = r_bht[w_if_idx][1];

    always_comb begin
        // NOTE: default first so every path assigns w_cls and no latch is inferred.
        w_cls = CLS_NONE;
        if (ex_valid) begin
            case (ex_op)
                OP_BRANCH: w_cls = CLS_BRANCH;
                OP_JAL:    w_cls = CLS_JAL;
                OP_JALR:   w_cls = CLS_JALR;
                default:   w_cls = CLS_NONE;
            endcase
        end
    end

    // Flags come from rs1-rs2; signed compares use N^V, unsigned use the carry.
    always_comb begin
        w_cond_ok = 1'b1;
        w_actual  = 1'b0;
        case (ex_funct3)
            3'b000:  w_actual = ex_zero;
            3'b001:  w_actual = ~ex_zero;
            3'b100:  w_actual = ex_negative ^ ex_overflow;
            3'b101:  w_actual = ~(ex_negative ^ ex_overflow);
            3'b110:  w_actual = ~ex_carry;
            3'b111:  w_actual = ex_carry;
            default: w_cond_ok = 1'b0;
        endcase
    end

    assign w_br_resolve = (w_cls == CLS_BRANCH) && w_cond_ok;
    assign w_mispred    = w_actual != ex_pred_taken;
    assign w_ctr_cur    = r_bht[w_ex_idx];

    always_comb begin
        w_ctr_next = w_ctr_cur;
        if (w_actual) begin
            if (w_ctr_cur != 2'b11) w_ctr_next = w_ctr_cur + 2'b01;
        end else begin
            if (w_ctr_cur != 2'b00) w_ctr_next = w_ctr_cur - 2'b01;
        end
    end

    // NOTE: the table is reset entry by entry because predictions must restart
    // from INIT_CTR; this keeps it in flops rather than a RAM macro.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ENTRIES; i++) r_bht[i] <= INIT_CTR;
            r_redirect      <= 1'b0;
            r_redirect_pc   <= '0;
            r_br_count      <= '0;
            r_mispred_count <= '0;
        end else begin
            // NOTE: non-blocking throughout so every register samples pre-edge values.
            r_redirect <= 1'b0;
            if (w_br_resolve) begin
                r_bht[w_ex_idx] <= w_ctr_next;
                r_redirect_pc   <= w_actual ? ex_target : w_fallthru;
                if (r_br_count != '1) r_br_count <= r_br_count + 1'b1;
                if (w_mispred) begin
                    r_redirect <= 1'b1;
                    if (r_mispred_count != '1) r_mispred_count <= r_mispred_count + 1'b1;
                end
            end else if (w_cls == CLS_JAL) begin
                r_redirect    <= 1'b1;
                r_redirect_pc <= ex_target;
            end else if (w_cls == CLS_JALR) begin
                r_redirect    <= 1'b1;
                r_redirect_pc <= {ex_target[XLEN-1:1], 1'b0};
            end
        end
    end

    assign redirect      = r_redirect;
    assign redirect_pc   = r_redirect_pc;
    assign br_count      = r_br_count;
    assign mispred_count = r_mispred_count;

    assign w_unused = ^{if_pc[XLEN-1:IDX_BITS+2], if_pc[1:0]};

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit; narrow counters make saturation reachable.
module tb_branch_predict_unit;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_ALU  = 7'b0110011;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [XLEN-1:0]  if_pc;
    logic             if_pred_taken;
    logic             ex_valid;
    logic [6:0]       ex_op;
    logic [2:0]       ex_funct3;
    logic [XLEN-1:0]  ex_pc;
    logic             ex_pred_taken;
    logic [XLEN-1:0]  ex_target;
    logic             ex_zero, ex_overflow, ex_carry, ex_negative;
    logic             redirect;
    logic [XLEN-1:0]  redirect_pc;
    logic [CNT_W-1:0] br_count;
    logic [CNT_W-1:0] mispred_count;

    int n_tests = 0;
    int n_fail  = 0;

    branch_predict_unit #(.IDX_BITS(6), .XLEN(XLEN), .CNT_W(CNT_W), .INIT_CTR(2'b01)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .if_pc         (if_pc),
        .if_pred_taken (if_pred_taken),
        .ex_valid      (ex_valid),
        .ex_op         (ex_op),
        .ex_funct3     (ex_funct3),
        .ex_pc         (ex_pc),
        .ex_pred_taken (ex_pred_taken),
        .ex_target     (ex_target),
        .ex_zero       (ex_zero),
        .ex_overflow   (ex_overflow),
        .ex_carry      (ex_carry),
        .ex_negative   (ex_negative),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .br_count      (br_count),
        .mispred_count (mispred_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // flags = {Z, N, V, C}; presents one instruction for the next edge.
    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] pc,
                         input logic pred, input logic [31:0] tgt, input logic [3:0] flags);
        ex_valid      = 1'b1;
        ex_op         = op;
        ex_funct3     = f3;
        ex_pc         = pc;
        ex_pred_taken = pred;
        ex_target     = tgt;
        {ex_zero, ex_negative, ex_overflow, ex_carry} = flags;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
    endtask

    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] pc,
                         input logic pred, input logic [31:0] tgt, input logic [3:0] flags);
        drive(op, f3, pc, pred, tgt, flags);
        step();
    endtask

    task automatic check_out(input string tag, input logic rd, input logic [31:0] rpc,
                             input int brc, input int mpc);
        check({tag, "_redirect"}, 64'(redirect), 64'(rd));
        if (rd || rpc != 32'hFFFF_FFFF) check({tag, "_rpc"}, 64'(redirect_pc), 64'(rpc));
        check({tag, "_br"}, 64'(br_count), 64'(brc));
        check({tag, "_mis"}, 64'(mispred_count), 64'(mpc));
    endtask

    task automatic check_pred(input string tag, input logic [31:0] pc, input logic exp);
        if_pc = pc;
        #1;
        check(tag, 64'(if_pred_taken), 64'(exp));
    endtask

    initial begin
        reset_n = 1'b0;
        if_pc = 32'h100;
        ex_valid = 1'b0; ex_op = '0; ex_funct3 = '0; ex_pc = '0; ex_pred_taken = 1'b0;
        ex_target = '0; {ex_zero, ex_negative, ex_overflow, ex_carry} = 4'b0;
        repeat (3) @(posedge clk);
        #1;
        check_out("rst", 1'b0, 32'h0, 0, 0);
        check_pred("rst_pred_100", 32'h100, 1'b0);
        check_pred("rst_pred_3c", 32'h3C, 1'b0);
        reset_n = 1'b1;
        step();
        check_out("idle", 1'b0, 32'h0, 0, 0);

        // beq taken, predicted not-taken: ctr 01 -> 10
        issue(OP_BR, 3'b000, 32'h100, 1'b0, 32'h140, 4'b1000);
        check_out("beq_mis", 1'b1, 32'h140, 1, 1);
        check_pred("beq_pred", 32'h100, 1'b1);

        // three more taken: ctr saturates at 11
        for (int i = 0; i < 3; i++) begin
            issue(OP_BR, 3'b000, 32'h100, 1'b1, 32'h140, 4'b1000);
            check_out("beq_hit", 1'b0, 32'h140, 2 + i, 1);
        end
        issue(OP_BR, 3'b000, 32'h100, 1'b1, 32'h140, 4'b0000);
        check_out("beq_nt", 1'b1, 32'h104, 5, 2);
        check_pred("beq_sat_pred", 32'h100, 1'b1);

        // flag sweep, each at its own BHT index
        issue(OP_BR, 3'b100, 32'h204, 1'b1, 32'h500, 4'b0100);   // blt N=1 V=0
        check_out("blt_t", 1'b0, 32'h500, 6, 2);
        issue(OP_BR, 3'b100, 32'h208, 1'b0, 32'h500, 4'b0110);   // blt N=V=1
        check_out("blt_nt", 1'b0, 32'h20C, 7, 2);
        issue(OP_BR, 3'b101, 32'h20C, 1'b1, 32'h600, 4'b1000);   // bge Z=1 N=V=0
        check_out("bge_z", 1'b0, 32'h600, 8, 2);
        issue(OP_BR, 3'b101, 32'h210, 1'b1, 32'h600, 4'b0100);   // bge N=1 V=0
        check_out("bge_nt", 1'b1, 32'h214, 9, 3);
        issue(OP_BR, 3'b110, 32'h214, 1'b1, 32'h700, 4'b0000);   // bltu C=0
        check_out("bltu_t", 1'b0, 32'h700, 10, 3);
        issue(OP_BR, 3'b111, 32'h218, 1'b0, 32'h800, 4'b0001);   // bgeu C=1
        check_out("bgeu_t", 1'b1, 32'h800, 11, 4);
        issue(OP_BR, 3'b001, 32'h21C, 1'b0, 32'h900, 4'b1000);   // bne Z=1
        check_out("bne_nt", 1'b0, 32'h220, 12, 4);
        check_pred("bne_ctr00", 32'h21C, 1'b0);

        // reserved funct3: no action at all
        issue(OP_BR, 3'b010, 32'h220, 1'b1, 32'hA00, 4'b1000);
        check_out("f3_010", 1'b0, 32'hFFFF_FFFF, 12, 4);
        issue(OP_BR, 3'b110, 32'h220, 1'b1, 32'hA00, 4'b0000);   // bltu at same idx: 01 -> 10
        check_pred("f3_010_bht", 32'h220, 1'b1);
        issue(OP_BR, 3'b011, 32'h220, 1'b0, 32'hA00, 4'b0001);
        check_out("f3_011", 1'b0, 32'hFFFF_FFFF, 13, 4);
        check_pred("f3_011_bht", 32'h220, 1'b1);

        // jumps
        issue(OP_JALR, 3'b000, 32'h31C, 1'b0, 32'h2001, 4'b0000);
        check_out("jalr", 1'b1, 32'h2000, 13, 4);
        check_pred("jalr_bht", 32'h31C, 1'b0);
        issue(OP_JAL, 3'b000, 32'h320, 1'b0, 32'h4000, 4'b0000);
        check_out("jal", 1'b1, 32'h4000, 13, 4);
        step();
        check_out("idle_after_jal", 1'b0, 32'h4000, 13, 4);
        issue(OP_ALU, 3'b000, 32'h324, 1'b1, 32'h5000, 4'b1000);
        check_out("alu", 1'b0, 32'h4000, 13, 4);

        // same-cycle lookup and update of index 0x10
        if_pc = 32'h240;
        drive(OP_BR, 3'b000, 32'h240, 1'b0, 32'h280, 4'b1000);
        #1;
        check("coll_old", 64'(if_pred_taken), 64'(1'b0));
        step();
        check("coll_new", 64'(if_pred_taken), 64'(1'b1));
        check_out("coll", 1'b1, 32'h280, 14, 5);

        // br_count 14 -> 15 -> stays 15
        for (int i = 0; i < 3; i++) begin
            issue(OP_BR, 3'b000, 32'h180, 1'b0, 32'h1C0, 4'b0000);
            check_out("br_sat", 1'b0, 32'h184, (i == 0) ? 15 : 15, 5);
        end

        // async reset while redirect is high
        issue(OP_JAL, 3'b000, 32'h400, 1'b0, 32'h6000, 4'b0000);
        check("pre_rst_redirect", 64'(redirect), 64'(1'b1));
        reset_n = 1'b0;
        #1;
        check_out("mid_rst", 1'b0, 32'h0, 0, 0);
        check_pred("mid_rst_bht", 32'h100, 1'b0);
        check_pred("mid_rst_bht2", 32'h220, 1'b0);
        #1;
        reset_n = 1'b1;
        issue(OP_BR, 3'b000, 32'h100, 1'b0, 32'h140, 4'b1000);
        check_out("post_rst", 1'b1, 32'h140, 1, 1);
        check_pred("post_rst_pred", 32'h100, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
Resolves branches and jumps for the pipelined core and predicts conditional branch direction at fetch. Prediction uses a table of 2-bit saturating counters (BHT) indexed by PC. The execute stage presents each resolved control-flow instruction. The block computes the actual outcome from ALU flags, trains the BHT, raises a registered redirect request on mispredict, and keeps branch/mispredict performance counters.

Parameters:
IDX_BITS, 6, log2 of BHT entries (entries = 2**IDX_BITS); index = pc[IDX_BITS+1:2]
XLEN, 32, PC/target width
CNT_W, 32, width of each performance counter
INIT_CTR, 2'b01, BHT entry value after reset (weakly not-taken)

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
if_pc  in  XLEN  fetch PC to predict
if_pred_taken  out  1  combinational prediction = BHT[idx(if_pc)][1]
ex_valid  in  1  execute-stage instruction valid this cycle
ex_op  in  7  opcode
ex_funct3  in  3  funct3
ex_pc  in  XLEN  PC of executing instruction
ex_pred_taken  in  1  prediction carried down the pipeline with this instruction
ex_target  in  XLEN  computed taken target
ex_zero, ex_overflow, ex_carry, ex_negative  in  1 each  ALU flags of rs1-rs2
redirect  out  1  registered one-cycle pulse: flush and refetch
redirect_pc  out  XLEN  registered refetch address, valid with redirect
br_count  out  CNT_W  conditional branches resolved
mispred_count  out  CNT_W  conditional-branch mispredicts

Behaviour:
- Reset (async, reset_n=0): every BHT entry = INIT_CTR; redirect=0; redirect_pc=0; br_count=0; mispred_count=0. Takes effect immediately, even mid-resolve; the first edge after release behaves normally.
- Instruction class, considered only when ex_valid=1:
  - branch: op 1100011.
  - jal: op 1101111.
  - jalr: op 1100111.
  - anything else: no action.
- Actual taken for branch:
  - beq 000: Z.
  - bne 001: ~Z.
  - blt 100: N^V.
  - bge 101: ~(N^V). This is the corrected form; Z is not a term.
  - bltu 110: ~C.
  - bgeu 111: C.
  - funct3 010/011: treat as not-taken, no BHT update, no counter increment.
- Branch resolve, at the next clock edge:
  - BHT[idx(ex_pc)] saturating update: taken -> +1 capped at 3; not-taken -> -1 floored at 0.
  - br_count +1.
  - If actual != ex_pred_taken: mispred_count +1 and redirect=1.
  - redirect_pc = ex_target if actual taken, else ex_pc+4 (modulo 2**XLEN).
- jal/jalr: always taken, never update the BHT or the counters.
  - The decode path does not redirect them, so they always assert redirect with redirect_pc=ex_target.
  - redirect_pc for jalr is ex_target with bit0 cleared.
- redirect latency: exactly 1 cycle after the ex_valid cycle. It is a single-cycle pulse unless the next cycle also resolves a mispredict or jump.
- Lookup/update collision: if idx(if_pc)==idx(ex_pc) in the same cycle, if_pred_taken reflects the pre-update value. There is no bypass.
- Counters saturate at all-ones; they never wrap.
- ex_valid=0: no state change; redirect deasserts next cycle.
- The index uses only pc[IDX_BITS+1:2]. Aliasing is permitted; there are no tags.

Test Plan:
- Reset then idle -> if_pred_taken=0 for any PC; redirect=0; both counters 0. Assert reset_n mid-run with redirect=1 -> outputs clear immediately, BHT back to 01.
- beq at pc 0x100, Z=1, ex_pred_taken=0, target 0x140 -> next cycle redirect=1, redirect_pc=0x140, br_count=1, mispred_count=1; a lookup of 0x100 now predicts taken (ctr 10).
- Same beq resolved taken 3 more times -> ctr saturates at 11. Then Z=0 with ex_pred_taken=1 -> redirect_pc=0x104, ctr 10, still predicts taken.
- blt/bge/bltu/bgeu flag sweep with N^V and C combinations, including bge with Z=1,N=V=0 -> actual taken. Each prediction-matching case -> redirect=0.
- jalr ex_target=0x2001 -> redirect_pc=0x2000, BHT and counters unchanged. jal -> redirect_pc=ex_target.
- Same-cycle lookup and update of one index -> if_pred_taken shows the old value, the new value the cycle after. Preload br_count to the all-ones edge, branch again -> br_count stays saturated.
